// File: rtl/dii_ring_pkt_fifo_pkg.sv
// Shared debug-ring types: flit layout, packet FIFO FSM states and default sizes.
package dii_package;
  localparam int DII_PKT_FIFO_DEPTH = 32;
  localparam int DII_PKT_MAX_LEN    = 16;
  localparam int DII_DATA_W         = 16;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DII_DATA_W-1:0] data;
  } dii_flit;

  typedef enum logic {W_PASS, W_DROP} wr_state_e;
  typedef enum logic {R_IDLE, R_SEND} rd_state_e;
endpackage

// File: rtl/dii_ring_pkt_fifo_mem.sv
// Flit storage: one synchronous write port, one asynchronous read port (distributed RAM).
module dii_pkt_fifo_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dii_ring_pkt_fifo.sv
// Store-and-forward packet buffer between two debug-ring segments.
// Packets are only presented downstream once their last flit is stored;
// over-long packets are truncated with a forced last and the tail dropped.
module dii_ring_pkt_fifo
  import dii_package::*;
#(
  parameter int DEPTH       = DII_PKT_FIFO_DEPTH,
  parameter int MAX_PKT_LEN = DII_PKT_MAX_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [15:0]            in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [15:0]            out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   oversize_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_LEN);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_PKT_LEN - 1);

  wr_state_e     w_q, w_d;
  rd_state_e     r_q, r_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] occ_q, occ_d, pkt_q, pkt_d;
  logic [LW-1:0] wlen_q, wlen_d;
  logic          err_q, err_d;
  logic          wr_acc, wr_en, wr_last, force_last, rd_en;
  logic [16:0]   rd_entry;
  dii_flit       head;

  // Head of queue is valid only while a complete packet is stored.
  assign head       = {pkt_q != '0, rd_entry};
  assign out_valid  = head.valid;
  assign out_last   = head.last;
  assign out_data   = head.data;
  // Dropping ignores occupancy; reset holds the upstream off.
  assign in_ready   = rst_n & ((w_q == W_DROP) | (occ_q != DEPTH_C));

  assign wr_acc     = in_valid & in_ready;
  assign force_last = (wlen_q == LEN_LAST) & ~in_last;
  assign wr_last    = in_last | force_last;
  assign wr_en      = wr_acc & (w_q == W_PASS);
  assign rd_en      = out_valid & out_ready;

  assign pkt_count    = pkt_q;
  assign oversize_err = err_q;

  dii_pkt_fifo_mem #(.DEPTH(DEPTH), .WIDTH(17)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i ({wr_last, in_data}),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  // Writer FSM, length counter, occupancy and packet count.
  always_comb begin
    w_d    = w_q;
    wlen_d = wlen_q;
    err_d  = err_q;
    occ_d  = occ_q + CW'(wr_en) - CW'(rd_en);
    pkt_d  = pkt_q + CW'(wr_en & wr_last) - CW'(rd_en & out_last);
    case (w_q)
      W_PASS: if (wr_acc) begin
        wlen_d = wr_last ? '0 : wlen_q + LW'(1);
        if (force_last) begin
          w_d   = W_DROP;
          err_d = 1'b1;
        end
      end
      W_DROP: if (wr_acc && in_last) w_d = W_PASS;
      default: w_d = W_PASS;
    endcase
  end

  // Reader FSM: tracks whether packets are in flight downstream.
  always_comb begin
    r_d = r_q;
    case (r_q)
      R_IDLE: if (pkt_q != '0) r_d = R_SEND;
      R_SEND: if (rd_en && out_last && pkt_d == '0) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  // State registers, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= W_PASS;
      r_q    <= R_IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      pkt_q  <= '0;
      wlen_q <= '0;
      err_q  <= 1'b0;
    end else begin
      w_q    <= w_d;
      r_q    <= r_d;
      occ_q  <= occ_d;
      pkt_q  <= pkt_d;
      wlen_q <= wlen_d;
      err_q  <= err_d;
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
    end
  end
endmodule

// File: tb/tb_dii_ring_pkt_fifo.sv
// Random traffic against a packet-level queue model of the ring FIFO.
module tb_dii_ring_pkt_fifo;
  localparam int DEPTH = 32;
  localparam int MAXL  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid, in_last, in_ready;
  logic [15:0]            in_data;
  logic                   out_valid, out_last, out_ready;
  logic [15:0]            out_data;
  logic [$clog2(DEPTH):0] pkt_count;
  logic                   oversize_err;

  always #5 clk = ~clk;

  dii_ring_pkt_fifo #(.DEPTH(DEPTH), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .pkt_count(pkt_count), .oversize_err(oversize_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: q_out holds complete packets visible downstream, part the packet being built.
  logic [16:0] q_out[$];
  logic [16:0] part[$];
  bit          drop, err;
  int          gen_rem;
  logic [15:0] cur_data;
  logic        cur_last;

  function automatic int npkts();
    int n = 0;
    foreach (q_out[i]) if (q_out[i][16]) n++;
    return n;
  endfunction

  function automatic bit m_rdy();
    return rst_n && (drop || (q_out.size() + part.size() < DEPTH));
  endfunction

  task automatic next_flit();
    if (gen_rem == 0) gen_rem = $urandom_range(20, 1);
    cur_data = 16'($urandom);
    cur_last = (gen_rem == 1);
  endtask

  task automatic flush_part();
    foreach (part[i]) q_out.push_back(part[i]);
    part.delete();
  endtask

  task automatic model_write(input logic last, input logic [15:0] d);
    if (drop) begin
      if (last) drop = 0;
    end else if (!last && part.size() == MAXL - 1) begin
      part.push_back({1'b1, d});
      flush_part();
      drop = 1;
      err  = 1;
    end else begin
      part.push_back({last, d});
      if (last) flush_part();
    end
  endtask

  task automatic check_outs();
    chk("in_ready", 32'(in_ready), 32'(m_rdy()));
    chk("out_valid", 32'(out_valid), 32'(q_out.size() != 0));
    chk("pkt_count", 32'(pkt_count), 32'(npkts()));
    chk("oversize_err", 32'(oversize_err), 32'(err));
    if (q_out.size() != 0) chk("out_flit", 32'({out_last, out_data}), 32'(q_out[0]));
  endtask

  // One clock: check at negedge+1, drive, apply model transfers at posedge.
  task automatic step(input int pv, input int pr);
    bit wacc, racc;
    #1 check_outs();
    in_valid  = ($urandom_range(99) < pv);
    out_ready = ($urandom_range(99) < pr);
    in_data   = cur_data;
    in_last   = cur_last;
    wacc = in_valid && m_rdy();
    racc = out_ready && (q_out.size() != 0);
    @(posedge clk);
    if (racc) void'(q_out.pop_front());
    if (wacc) begin
      model_write(cur_last, cur_data);
      gen_rem--;
      next_flit();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cyc);
    #2 rst_n = 1'b0;
    q_out.delete();
    part.delete();
    drop = 0;
    err = 0;
    gen_rem = 0;
    next_flit();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_pkt_count", 32'(pkt_count), 32'(0));
    chk("rst_oversize", 32'(oversize_err), 32'(0));
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit reached;
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    drop = 0; err = 0; gen_rem = 0;
    next_flit();
    repeat (3) @(negedge clk);
    #1 check_outs();
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step(80, 80);
    // Upstream-heavy: fills the buffer and exercises full/blocked writes.
    for (int i = 0; i < 200; i++) step(95, 8);
    for (int i = 0; i < 150; i++) step(90, 100);

    // Reset in the middle of a partially stored packet.
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      if (part.size() >= 5) reached = 1;
      else step(100, 100);
    end
    chk("midpkt_reached", 32'(reached), 32'(1));
    apply_reset(2);

    for (int i = 0; i < 300; i++) step(50, 50);
    for (int i = 0; i < 150; i++) step(100, 100);
    for (int i = 0; i < 100; i++) step(95, 3);
    for (int i = 0; i < 100; i++) step(0, 100);
    step(0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
